pipeline_fetch: RTL and testbench

//   Stage-1 instruction fetch. Produces the pc_in/instr pair consumed by the decode stage (pipeline2).

---
 rtl/pipeline_fetch.sv | 135 +++++++++++++
 tb/tb_pipeline_fetch.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch.sv
// Stage-1 instruction fetch: PC register, 1-cycle synchronous imem read, skid buffer for
// decode stalls and squash-to-bubble on downstream redirects.
module pipeline_fetch #(
    parameter int                        PC_WIDTH     = 16,
    parameter int                        INSTR_WIDTH  = 32,
    parameter int                        OPCODE_WIDTH = 6,
    parameter logic [PC_WIDTH-1:0]       RESET_PC     = '0,
    parameter logic [OPCODE_WIDTH-1:0]   NOP_OPCODE   = '0
) (
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic                   stall,
    input  logic                   redirect_en,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   valid
);

    localparam logic [INSTR_WIDTH-1:0] NOP_WORD =
        {{(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}, NOP_OPCODE};
    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [PC_WIDTH-1:0]    pc_q;
    logic [PC_WIDTH-1:0]    f_pc_q;
    logic                   f_vld_q;
    logic [INSTR_WIDTH-1:0] skid_instr_q;
    logic [PC_WIDTH-1:0]    skid_pc_q;
    logic                   skid_vld_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    pc_out_q;
    logic                   valid_q;

    logic active;
    logic squash;
    logic issue;
    logic load_from_mem;
    logic load_from_skid;
    logic capture_skid;

    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:        state_d = RUN;
            RUN, FLUSH:  state_d = stall ? HOLD : RUN;
            HOLD:        state_d = stall ? HOLD : RUN;
            default:     state_d = BOOT;
        endcase
        // A redirect beats stall and restarts the bubble window from any live state.
        if (state_q != BOOT && redirect_en) begin
            state_d = FLUSH;
        end
    end

    always_comb begin
        active         = (state_q != BOOT);
        squash         = active & redirect_en;
        issue          = active & ~stall & ~redirect_en;
        load_from_mem  = issue & ((state_q == RUN) | (state_q == FLUSH));
        load_from_skid = issue & (state_q == HOLD);
        capture_skid   = active & stall & ~redirect_en &
                         ((state_q == RUN) | (state_q == FLUSH));
        imem_en        = active & ~stall;
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            pc_q         <= RESET_PC;
            f_pc_q       <= '0;
            f_vld_q      <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_vld_q   <= 1'b0;
            instr_q      <= NOP_WORD;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
        end else if (squash) begin
            pc_q       <= redirect_pc;
            f_vld_q    <= 1'b0;
            skid_vld_q <= 1'b0;
            instr_q    <= NOP_WORD;
            valid_q    <= 1'b0;
        end else begin
            if (issue) begin
                pc_q    <= pc_q + PC_ONE;
                f_pc_q  <= pc_q;
                f_vld_q <= 1'b1;
            end
            if (load_from_mem) begin
                instr_q  <= f_vld_q ? imem_data : NOP_WORD;
                pc_out_q <= f_pc_q;
                valid_q  <= f_vld_q;
            end
            if (load_from_skid) begin
                instr_q    <= skid_vld_q ? skid_instr_q : NOP_WORD;
                pc_out_q   <= skid_pc_q;
                valid_q    <= skid_vld_q;
                skid_vld_q <= 1'b0;
            end
            // The read returning this cycle would be lost once decode stalls, so park it.
            if (capture_skid) begin
                skid_instr_q <= imem_data;
                skid_pc_q    <= f_pc_q;
                skid_vld_q   <= f_vld_q;
                f_vld_q      <= 1'b0;
            end
        end
    end

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign pc_out    = pc_out_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_pipeline_fetch.sv
// Randomized scoreboard bench for pipeline_fetch: a decode-side monitor checks every consumed
// word against the expected address stream plus bubble and latency rules.
module tb_pipeline_fetch;

    localparam logic [15:0] RESET_PC = 16'd0;
    localparam logic [5:0]  NOP_OP   = 6'h2A;
    localparam logic [31:0] NOP_WORD = {26'd0, NOP_OP};

    logic        clk_in = 1'b0;
    logic        RST = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic [31:0] instr;
    logic [15:0] pc_out;
    logic        valid;

    pipeline_fetch #(
        .PC_WIDTH    (16),
        .INSTR_WIDTH (32),
        .OPCODE_WIDTH(6),
        .RESET_PC    (RESET_PC),
        .NOP_OPCODE  (NOP_OP)
    ) dut (
        .clk_in     (clk_in),
        .RST        (RST),
        .stall      (stall),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .instr      (instr),
        .pc_out     (pc_out),
        .valid      (valid)
    );

    always #5 clk_in = ~clk_in;

    logic [31:0] mem [0:65535];

    always @(posedge clk_in) begin
        if (imem_en) imem_data <= mem[imem_addr];
    end

    int n_checks = 0;
    int n_fail = 0;
    int n_consumed = 0;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected consumption order: fetch addresses from the latest restart point, consecutively.
    logic [15:0] exp_q[$];
    logic [15:0] next_pc;
    logic        last_r = 1'b1;

    task automatic seed(input logic [15:0] start);
        exp_q.delete();
        next_pc = start;
    endtask

    task automatic topup();
        while (exp_q.size() < 32) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 16'd1;
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic d, input logic [15:0] p);
        RST = r;
        stall = s;
        redirect_en = d;
        redirect_pc = p;
        if (r) seed(RESET_PC);
        else if (d) seed(p);
        topup();
        last_r = r;
        @(posedge clk_in);
        #1;
    endtask

    // Inputs applied at recent edges; index 1 is the edge just before this negedge.
    bit          h_rst   [1:4] = '{0, 0, 0, 0};
    bit          h_stall [1:4] = '{0, 0, 0, 0};
    bit          h_redir [1:4] = '{0, 0, 0, 0};
    logic [15:0] h_rpc   [1:4] = '{0, 0, 0, 0};
    bit          p_rst = 1'b1, p_stall = 1'b0, p_redir = 1'b0;
    logic [15:0] p_rpc = '0;

    always @(negedge clk_in) begin
        for (int i = 4; i > 1; i--) begin
            h_rst[i]   = h_rst[i-1];
            h_stall[i] = h_stall[i-1];
            h_redir[i] = h_redir[i-1];
            h_rpc[i]   = h_rpc[i-1];
        end
        h_rst[1] = p_rst; h_stall[1] = p_stall; h_redir[1] = p_redir; h_rpc[1] = p_rpc;

        if (h_rst[1]) begin
            chk("reset_valid", {47'd0, valid}, 48'd0);
            chk("reset_instr", {16'd0, instr}, {16'd0, NOP_WORD});
            chk("reset_pc_out", {32'd0, pc_out}, 48'd0);
        end else begin
            if (valid === 1'b0) chk("bubble_nop", {16'd0, instr}, {16'd0, NOP_WORD});
            if (h_redir[1] && !h_rst[2])
                chk("redir_bubble1", {47'd0, valid}, 48'd0);
            if (h_redir[2] && !h_rst[2] && !h_rst[3])
                chk("redir_bubble2", {47'd0, valid}, 48'd0);
            if (h_redir[3] && !h_rst[3] && !h_rst[4] && !h_rst[2] && !h_stall[2] &&
                !h_stall[1] && !h_redir[2] && !h_redir[1]) begin
                chk("redir_latency_valid", {47'd0, valid}, 48'd1);
                chk("redir_latency_pc", {32'd0, pc_out}, {32'd0, h_rpc[3]});
            end
            if (h_rst[2]) chk("boot_valid", {47'd0, valid}, 48'd0);
            if (h_rst[3] && !h_rst[2]) chk("boot_bubble", {47'd0, valid}, 48'd0);
            if (h_rst[4] && !h_rst[3] && !h_rst[2] && !h_stall[2] && !h_stall[1] &&
                !h_redir[2] && !h_redir[1]) begin
                chk("boot_latency_valid", {47'd0, valid}, 48'd1);
                chk("boot_latency_pc", {32'd0, pc_out}, {32'd0, RESET_PC});
            end
            // Decode accepts the presented word at the next edge unless stalled or squashing.
            if (valid === 1'b1 && !stall && !redirect_en && !RST) begin
                n_consumed++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_underflow: got pc_out %0d, expected no word", pc_out);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("stream_pc", {32'd0, pc_out}, {32'd0, e});
                    chk("stream_instr", {16'd0, instr}, {16'd0, mem[e]});
                end
            end
        end

        p_rst = RST; p_stall = stall; p_redir = redirect_en; p_rpc = redirect_pc;
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        mem[0] = {16'd85, 5'd0, 5'd31, 6'h01};
        mem[1] = {16'd105, 5'd17, 5'd3, 6'h02};

        repeat (3) drive(1, 0, 0, 0);
        repeat (10) drive(0, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 0);
        repeat (4) drive(0, 0, 0, 0);
        drive(0, 0, 1, 16'd758);
        repeat (6) drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 16'd1024);
        repeat (6) drive(0, 0, 0, 0);
        drive(0, 0, 1, 16'd65535);
        repeat (6) drive(0, 0, 0, 0);
        repeat (2) drive(0, 1, 0, 0);
        repeat (2) drive(1, 1, 0, 0);
        repeat (8) drive(0, 0, 0, 0);
        drive(0, 0, 1, 16'd100);
        drive(0, 0, 1, 16'd200);
        repeat (6) drive(0, 0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                repeat ($urandom_range(1, 2)) drive(1, $urandom_range(0, 1) == 1, 0, 0);
            end else begin
                logic        s, d;
                logic [15:0] p;
                s = ($urandom_range(0, 99) < 30);
                d = !last_r && ($urandom_range(0, 99) < 5);
                p = ($urandom_range(0, 4) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                : 16'($urandom);
                drive(0, s, d, p);
            end
        end
        repeat (4) drive(0, 0, 0, 0);

        chk("words_consumed", {47'd0, n_consumed > 500}, 48'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
